a2d_rr_sched: RTL and testbench

Round-robin conversion scheduler for the off-board ADC128S A2D converter. Each `nxt` request runs one complete two-transaction SPI conversion through the existing SPI master on the next channel in the fixed sequence: left load cell, right load cell, steering pot, battery. The converted 12-bit value is captured into a per-channel holding register. The block sits between the SPI master and the rider-detect, steering and battery-monitor logic in the Segway top level.

---
 rtl/a2d_rr_sched_if.sv | 25 ++
 rtl/a2d_rr_sched.sv | 130 +++++++++++++
 tb/tb_a2d_rr_sched.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/a2d_rr_sched_if.sv
// rtl/a2d_rr_sched_if.sv - request, SPI-master and result signals of the A2D round-robin scheduler
interface a2d_rr_sched_if;
    logic        nxt;
    logic        wrt;
    logic [15:0] cmd;
    logic        done;
    logic [15:0] resp;
    logic [11:0] lft_ld;
    logic [11:0] rght_ld;
    logic [11:0] steer_pot;
    logic [11:0] batt;
    logic        cnv_cmplt;
    logic        busy;
    logic [1:0]  chnl;

    modport slave (
        input  nxt, done, resp,
        output wrt, cmd, lft_ld, rght_ld, steer_pot, batt, cnv_cmplt, busy, chnl
    );

    modport master (
        output nxt, done, resp,
        input  wrt, cmd, lft_ld, rght_ld, steer_pot, batt, cnv_cmplt, busy, chnl
    );
endinterface

// File: rtl/a2d_rr_sched.sv
// rtl/a2d_rr_sched.sv - round-robin ADC128S conversion scheduler driving the SPI master
module a2d_rr_sched #(
    parameter logic [2:0] CH_LFT   = 3'd0,
    parameter logic [2:0] CH_RGHT  = 3'd4,
    parameter logic [2:0] CH_STEER = 3'd5,
    parameter logic [2:0] CH_BATT  = 3'd6
) (
    input  logic             clk,
    input  logic             rst,
    a2d_rr_sched_if.slave    bus
);

    typedef enum logic [2:0] {IDLE, ADDR, GAP, READ, CMPLT} state_t;

    state_t      state_q, state_d;
    logic        wrt_q, wrt_d;
    logic [15:0] cmd_q, cmd_d;
    logic [11:0] lft_q, lft_d;
    logic [11:0] rght_q, rght_d;
    logic [11:0] steer_q, steer_d;
    logic [11:0] batt_q, batt_d;
    logic        cmplt_q, cmplt_d;
    logic        busy_q, busy_d;
    logic [1:0]  chnl_q, chnl_d;
    logic [2:0]  ch_sel;

    always_comb begin
        ch_sel = CH_LFT;
        case (chnl_q)
            2'd0: ch_sel = CH_LFT;
            2'd1: ch_sel = CH_RGHT;
            2'd2: ch_sel = CH_STEER;
            2'd3: ch_sel = CH_BATT;
            default: ch_sel = CH_LFT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            wrt_q   <= 1'b0;
            cmd_q   <= 16'h0000;
            lft_q   <= 12'h000;
            rght_q  <= 12'h000;
            steer_q <= 12'h000;
            batt_q  <= 12'h000;
            cmplt_q <= 1'b0;
            busy_q  <= 1'b0;
            chnl_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            wrt_q   <= wrt_d;
            cmd_q   <= cmd_d;
            lft_q   <= lft_d;
            rght_q  <= rght_d;
            steer_q <= steer_d;
            batt_q  <= batt_d;
            cmplt_q <= cmplt_d;
            busy_q  <= busy_d;
            chnl_q  <= chnl_d;
        end
    end

    // Outputs are all registered, so each transition sets what the next state shows.
    always_comb begin
        state_d = state_q;
        wrt_d   = 1'b0;
        cmd_d   = cmd_q;
        lft_d   = lft_q;
        rght_d  = rght_q;
        steer_d = steer_q;
        batt_d  = batt_q;
        cmplt_d = 1'b0;
        busy_d  = busy_q;
        chnl_d  = chnl_q;
        case (state_q)
            IDLE: begin
                if (bus.nxt) begin
                    wrt_d   = 1'b1;
                    cmd_d   = {2'b00, ch_sel, 11'h000};
                    busy_d  = 1'b1;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (bus.done) state_d = GAP;
            end
            GAP: begin
                wrt_d   = 1'b1;
                state_d = READ;
            end
            READ: begin
                // The first response belonged to the previous address; only this one is kept.
                if (bus.done) begin
                    case (chnl_q)
                        2'd0: lft_d   = bus.resp[11:0];
                        2'd1: rght_d  = bus.resp[11:0];
                        2'd2: steer_d = bus.resp[11:0];
                        2'd3: batt_d  = bus.resp[11:0];
                        default: lft_d = lft_q;
                    endcase
                    cmplt_d = 1'b1;
                    chnl_d  = chnl_q + 2'd1;
                    state_d = CMPLT;
                end
            end
            CMPLT: begin
                busy_d  = 1'b0;
                cmd_d   = 16'h0000;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                cmd_d   = 16'h0000;
                state_d = IDLE;
            end
        endcase
    end

    assign bus.wrt       = wrt_q;
    assign bus.cmd       = cmd_q;
    assign bus.lft_ld    = lft_q;
    assign bus.rght_ld   = rght_q;
    assign bus.steer_pot = steer_q;
    assign bus.batt      = batt_q;
    assign bus.cnv_cmplt = cmplt_q;
    assign bus.busy      = busy_q;
    assign bus.chnl      = chnl_q;

endmodule

// File: tb/tb_a2d_rr_sched.sv
// tb/tb_a2d_rr_sched.sv - self-checking bench for a2d_rr_sched with a scripted SPI/ADC responder
module tb_a2d_rr_sched;

    logic clk;
    logic rst;
    a2d_rr_sched_if bus ();

    a2d_rr_sched dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [11:0] exp_regs [4];
    int          exp_ch;
    int          ch_addr [4] = '{0, 4, 5, 6};

    typedef struct {
        logic [15:0] r1;
        logic [15:0] r2;
        int          l1;
        int          l2;
        bit          rej;
        int          slot;
        logic [11:0] exp_val;
        logic [15:0] exp_cmd;
        logic [1:0]  exp_chnl;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] get_reg(input int k);
        case (k)
            0: return bus.lft_ld;
            1: return bus.rght_ld;
            2: return bus.steer_pot;
            default: return bus.batt;
        endcase
    endfunction

    task automatic chk_regs(input string name);
        for (int k = 0; k < 4; k++) chk($sformatf("%s_reg%0d", name, k), get_reg(k), exp_regs[k]);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) exp_regs[k] = 12'h000;
        exp_ch = 0;
    endtask

    // Inputs change on negedge after the outputs of the previous posedge have been sampled.
    task automatic run_conv(input logic [15:0] r1, input logic [15:0] r2, input int l1,
                            input int l2, input bit rej, output logic [15:0] obs_cmd);
        logic [15:0] ecmd;
        int stray;
        ecmd  = 16'(ch_addr[exp_ch] * 2048);
        stray = 0;
        @(negedge clk);
        bus.nxt = 1'b1;
        @(negedge clk);
        bus.nxt = rej;
        obs_cmd = bus.cmd;
        chk("wrt_first", bus.wrt, 1);
        chk("busy_start", bus.busy, 1);
        chk("cmd_first", bus.cmd, ecmd);
        for (int i = 0; i < l1; i++) begin
            @(negedge clk);
            bus.nxt = 1'b0;
            if (bus.wrt !== 1'b0 || bus.busy !== 1'b1) stray++;
        end
        bus.done = 1'b1;
        bus.resp = r1;
        @(negedge clk);
        bus.done = 1'b0;
        bus.nxt  = 1'b0;
        bus.resp = 16'($urandom);
        chk("wrt_gap", bus.wrt, 0);
        @(negedge clk);
        chk("wrt_second", bus.wrt, 1);
        chk("cmd_second", bus.cmd, ecmd);
        bus.nxt = rej;
        for (int i = 0; i < l2; i++) begin
            @(negedge clk);
            bus.nxt = 1'b0;
            if (bus.wrt !== 1'b0 || bus.cnv_cmplt !== 1'b0 || bus.cmd !== ecmd) stray++;
        end
        chk("stray_activity", stray, 0);
        bus.done = 1'b1;
        bus.resp = r2;
        @(negedge clk);
        bus.done = rej;
        bus.resp = 16'hDEAD;
        bus.nxt  = rej;
        exp_regs[exp_ch] = r2[11:0];
        exp_ch = (exp_ch + 1) % 4;
        chk("cnv_cmplt", bus.cnv_cmplt, 1);
        chk("busy_cmplt", bus.busy, 1);
        chk("chnl_adv", bus.chnl, exp_ch);
        chk_regs("capture");
        @(negedge clk);
        bus.done = 1'b0;
        bus.nxt  = 1'b0;
        chk("cmplt_once", bus.cnv_cmplt, 0);
        chk("busy_end", bus.busy, 0);
        chk("cmd_idle", bus.cmd, 0);
        chk("wrt_idle", bus.wrt, 0);
        @(negedge clk);
        chk("no_queued_nxt", {bus.wrt, bus.busy}, 0);
        if (rej) chk_regs("ignored_done");
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    logic [15:0] obs;
    int bad;

    initial begin
        bus.nxt  = 1'b0;
        bus.done = 1'b0;
        bus.resp = 16'h0000;
        rst      = 1'b0;
        model_reset();

        vecs[0] = '{16'h0000, 16'h0400, 2, 3, 1'b0, 0, 12'h400, 16'h0000, 2'd1};
        vecs[1] = '{16'h0400, 16'h03C0, 0, 0, 1'b0, 1, 12'h3C0, 16'h2000, 2'd2};
        vecs[2] = '{16'h13C0, 16'h0800, 5, 1, 1'b0, 2, 12'h800, 16'h2800, 2'd3};
        vecs[3] = '{16'h0800, 16'hFFFF, 1, 4, 1'b0, 3, 12'hFFF, 16'h3000, 2'd0};
        vecs[4] = '{16'h0FFF, 16'hA400, 3, 2, 1'b0, 0, 12'h400, 16'h0000, 2'd1};
        vecs[5] = '{16'h0400, 16'h73C0, 1, 1, 1'b0, 1, 12'h3C0, 16'h2000, 2'd2};
        vecs[6] = '{16'h03C0, 16'h0800, 2, 2, 1'b0, 2, 12'h800, 16'h2800, 2'd3};
        vecs[7] = '{16'hFABC, 16'h0123, 3, 3, 1'b0, 3, 12'h123, 16'h3000, 2'd0};
        vecs[8] = '{16'h0123, 16'h0555, 2, 3, 1'b1, 0, 12'h555, 16'h0000, 2'd1};

        do_reset();
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if ({bus.wrt, bus.cmd, bus.lft_ld, bus.rght_ld, bus.steer_pot, bus.batt,
                 bus.cnv_cmplt, bus.busy, bus.chnl} !== '0) bad++;
        end
        chk("reset_quiet_cycles", bad, 0);

        for (int i = 0; i < 9; i++) begin
            run_conv(vecs[i].r1, vecs[i].r2, vecs[i].l1, vecs[i].l2, vecs[i].rej, obs);
            chk($sformatf("vec%0d_cmd", i), obs, vecs[i].exp_cmd);
            chk($sformatf("vec%0d_value", i), get_reg(vecs[i].slot), vecs[i].exp_val);
            chk($sformatf("vec%0d_chnl", i), bus.chnl, vecs[i].exp_chnl);
        end
        chk("stale_rght_kept", bus.rght_ld, 12'h3C0);

        // Reset between the two write pulses of a right-channel conversion.
        do_reset();
        run_conv(16'h0000, 16'h0777, 1, 1, 1'b0, obs);
        @(negedge clk);
        bus.nxt = 1'b1;
        @(negedge clk);
        bus.nxt = 1'b0;
        chk("midrst_cmd_before", bus.cmd, 16'h2000);
        bus.done = 1'b1;
        bus.resp = 16'h0777;
        @(negedge clk);
        bus.done = 1'b0;
        chk("midrst_in_gap", bus.wrt, 0);
        rst = 1'b1;
        #1;
        chk("midrst_async", {bus.wrt, bus.cmd, bus.lft_ld, bus.rght_ld, bus.steer_pot,
                             bus.batt, bus.cnv_cmplt, bus.busy, bus.chnl}, 0);
        repeat (3) @(negedge clk);
        chk("midrst_hold_wrt", bus.wrt, 0);
        rst = 1'b0;
        model_reset();
        run_conv(16'h0000, 16'h0ABC, 2, 2, 1'b0, obs);
        chk("midrst_first_cmd", obs, 16'h0000);
        chk("midrst_lft", bus.lft_ld, 12'hABC);

        do_reset();
        for (int i = 0; i < 9; i++)
            run_conv(16'($urandom), 16'($urandom), $urandom_range(0, 6), $urandom_range(0, 6),
                     ($urandom_range(0, 3) == 0), obs);
        chk("wrap_chnl", bus.chnl, 1);
        for (int i = 0; i < 20; i++)
            run_conv(16'($urandom), 16'($urandom), $urandom_range(0, 8), $urandom_range(0, 8),
                     ($urandom_range(0, 2) == 0), obs);
        chk("rand_final_chnl", bus.chnl, exp_ch);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
